// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Fetch stage of the single-issue RV32I core. Holds the PC, issues in-order
// word requests to instruction memory, buffers the returned words in a
// 2-entry FIFO and presents one instruction per cycle to decode.
//
// Ports
//   clk, rst_n         single rising-edge clock, synchronous active-low reset
//   imem_req_valid     fetch request valid
//   imem_req_addr      word-aligned fetch address (the current pc)
//   imem_req_ready     memory accepts the request this cycle
//   imem_rsp_valid     in-order response, not backpressurable
//   imem_rsp_data      returned instruction word
//   redirect_valid     load a new pc (taken branch / jump), highest priority
//   redirect_pc        redirect target, bits [1:0] ignored
//   stall              decode cannot accept this cycle
//   if_valid           if_pc / if_instr hold a valid instruction
//   if_pc              pc of the presented instruction (0 when empty)
//   if_instr           presented instruction (NOP_INSTR when empty)
//   if_opcode          if_instr[6:0], feeds MainControl
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [6:0]  if_opcode
);

  // Control state
  logic [31:0] pc;
  logic [1:0]  outstanding;
  logic [1:0]  drop;
  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic        inflight_rd;
  logic        inflight_wr;

  // Data storage (not reset)
  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic [31:0] inflight_pc[2];

  logic        deq;
  logic        req_fire;
  logic        fifo_wr;
  logic        fifo_rd;
  logic [2:0]  credit_used;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    if_valid       = rst_n && (count != 2'd0);
    deq            = if_valid && !stall;
    // Slots that will be occupied after this cycle's pop: in-flight requests
    // plus buffered entries. A new request needs a guaranteed FIFO slot.
    credit_used    = {1'b0, outstanding} + {1'b0, count} - {2'b00, deq};
    imem_req_valid = rst_n && !redirect_valid && (credit_used < 3'd2);
    imem_req_addr  = pc;
    req_fire       = imem_req_valid && imem_req_ready;
    // A redirect squashes both the same-cycle write and the same-cycle pop.
    fifo_wr        = imem_rsp_valid && (drop == 2'd0) && !redirect_valid;
    fifo_rd        = deq && !redirect_valid;
    if_pc          = if_valid ? fifo_pc[rd_ptr]    : 32'h0000_0000;
    if_instr       = if_valid ? fifo_instr[rd_ptr] : NOP_INSTR;
  end

  assign if_opcode = if_instr[6:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= 2'd0;
      drop        <= 2'd0;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      inflight_rd <= 1'b0;
      inflight_wr <= 1'b0;
    end else begin
      // The in-flight pc queue tracks every accepted request, including ones
      // that will later be dropped, so it stays aligned with the responses.
      outstanding <= outstanding + {1'b0, req_fire} - {1'b0, imem_rsp_valid};
      if (req_fire)       inflight_wr <= ~inflight_wr;
      if (imem_rsp_valid) inflight_rd <= ~inflight_rd;

      if (redirect_valid) begin
        pc     <= {redirect_pc[31:2], 2'b00};
        // Everything still in flight after this cycle belongs to the old path.
        drop   <= outstanding - {1'b0, imem_rsp_valid};
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (imem_rsp_valid && (drop != 2'd0)) drop <= drop - 2'd1;
        if (fifo_wr) wr_ptr <= ~wr_ptr;
        if (fifo_rd) rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, fifo_wr} - {1'b0, fifo_rd};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) inflight_pc[inflight_wr] <= pc;
    if (fifo_wr) begin
      fifo_pc[wr_ptr]    <= inflight_pc[inflight_rd];
      fifo_instr[wr_ptr] <= imem_rsp_data;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(imem_rsp_valid && (drop == 2'd0) && (count == 2'd2)))
        else $error("instr_fetch_unit: response arrived with FIFO full");
      assert (!(imem_rsp_valid && (outstanding == 2'd0)))
        else $error("instr_fetch_unit: response with no outstanding request");
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [6:0]  if_opcode;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_opcode      (if_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    lat;
  int    cyc;
  int    n_chk;
  int    n_pass;

  // Snapshot of DUT outputs for the cycle just stepped
  logic        s_req_v;
  logic [31:0] s_req_a;
  logic        s_ifv;
  logic [31:0] s_ifpc;
  logic [31:0] s_instr;
  logic [6:0]  s_op;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock cycle: present any due memory response, sample outputs,
  // record a handshake, then advance to the next falling edge.
  task automatic step();
    mreq_t m;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      m = mq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = m.addr | 32'h1;
    end
    #1;
    s_req_v = imem_req_valid;
    s_req_a = imem_req_addr;
    s_ifv   = if_valid;
    s_ifpc  = if_pc;
    s_instr = if_instr;
    s_op    = if_opcode;
    if (rst_n && imem_req_valid && imem_req_ready) begin
      m.addr = imem_req_addr;
      m.due  = cyc + lat;
      mq.push_back(m);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    mq.delete();
    step();
    step();
    chk("rst_req_valid", {31'b0, s_req_v}, 32'h0);
    chk("rst_if_valid",  {31'b0, s_ifv},   32'h0);
    chk("rst_if_pc",     s_ifpc,           32'h0);
    chk("rst_if_instr",  s_instr,          32'h13);
    rst_n = 1'b1;
    cyc   = 1;
  endtask

  task automatic chk_instr(input string tag, input logic [31:0] epc);
    logic [31:0] ei;
    logic [6:0]  eo;
    ei = epc | 32'h1;
    eo = ei[6:0];
    chk({tag, "_valid"},  {31'b0, s_ifv}, 32'h1);
    chk({tag, "_pc"},     s_ifpc,         epc);
    chk({tag, "_instr"},  s_instr,        ei);
    chk({tag, "_opcode"}, {25'b0, s_op},  {25'b0, eo});
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; lat = 1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;

    // Straight-line fetch, 1-cycle memory
    do_reset();
    lat = 1;
    step(); // c1
    chk("sl_c1_req_v", {31'b0, s_req_v}, 32'h1);
    chk("sl_c1_addr",  s_req_a, 32'h0);
    chk("sl_c1_ifv",   {31'b0, s_ifv}, 32'h0);
    step(); // c2
    chk("sl_c2_addr",  s_req_a, 32'h4);
    chk("sl_c2_ifv",   {31'b0, s_ifv}, 32'h0);
    for (int k = 3; k <= 8; k++) begin
      step();
      chk_instr("sl_out", 32'(4 * (k - 3)));
      chk("sl_addr", s_req_a, 32'(4 * (k - 1)));
    end

    // Stall for 5 cycles mid-stream
    stall = 1'b1;
    for (int k = 9; k <= 13; k++) begin
      step();
      chk("st_pc_hold", s_ifpc, 32'd24);
      chk("st_req_v",   {31'b0, s_req_v}, 32'h0);
    end
    chk("st_inflight", 32'(mq.size()), 32'd0);
    stall = 1'b0;
    step(); // c14
    chk_instr("st_c14", 32'd24);
    chk("st_c14_addr", s_req_a, 32'd32);
    for (int k = 15; k <= 17; k++) begin
      step();
      chk_instr("st_resume", 32'(4 * (k - 8)));
    end

    // Redirect with two requests in flight, 3-cycle memory
    do_reset();
    lat = 3;
    step(); // c1
    chk("rd_c1_addr", s_req_a, 32'h0);
    step(); // c2
    chk("rd_c2_addr", s_req_a, 32'h4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step(); // c3
    redirect_valid = 1'b0;
    chk("rd_c3_req_v", {31'b0, s_req_v}, 32'h0);
    step(); // c4
    chk("rd_c4_req_v", {31'b0, s_req_v}, 32'h0);
    chk("rd_c4_ifv",   {31'b0, s_ifv},   32'h0);
    step(); // c5
    chk("rd_c5_req_v", {31'b0, s_req_v}, 32'h1);
    chk("rd_c5_addr",  s_req_a, 32'h100);
    chk("rd_c5_ifv",   {31'b0, s_ifv},   32'h0);
    step(); // c6
    chk("rd_c6_addr",  s_req_a, 32'h104);
    chk("rd_c6_ifv",   {31'b0, s_ifv},   32'h0);
    step(); // c7
    chk("rd_c7_req_v", {31'b0, s_req_v}, 32'h0);
    chk("rd_c7_ifv",   {31'b0, s_ifv},   32'h0);
    step(); // c8
    chk("rd_c8_ifv",   {31'b0, s_ifv},   32'h0);
    step(); // c9
    chk_instr("rd_c9", 32'h100);
    step(); // c10
    chk_instr("rd_c10", 32'h104);
    step(); // c11
    chk("rd_c11_ifv",  {31'b0, s_ifv},   32'h0);
    step(); // c12
    chk("rd_c12_ifv",  {31'b0, s_ifv},   32'h0);
    step(); // c13
    chk_instr("rd_c13", 32'h108);

    // Redirect coincident with a response, misaligned target
    do_reset();
    lat = 1;
    step(); // c1
    step(); // c2
    chk("co_c2_addr", s_req_a, 32'h4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    step(); // c3: response for 0x4 arrives here
    redirect_valid = 1'b0;
    chk("co_c3_req_v", {31'b0, s_req_v}, 32'h0);
    chk("co_c3_pc",    s_ifpc, 32'h0);
    step(); // c4
    chk("co_c4_req_v", {31'b0, s_req_v}, 32'h1);
    chk("co_c4_addr",  s_req_a, 32'h200);
    chk("co_c4_ifv",   {31'b0, s_ifv},   32'h0);
    step(); // c5
    chk("co_c5_ifv",   {31'b0, s_ifv},   32'h0);
    chk("co_c5_addr",  s_req_a, 32'h204);
    step(); // c6
    chk_instr("co_c6", 32'h200);
    step(); // c7
    chk_instr("co_c7", 32'h204);

    // Memory backpressure and address wrap
    do_reset();
    lat = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step(); // c1
    redirect_valid = 1'b0;
    chk("bp_c1_req_v", {31'b0, s_req_v}, 32'h0);
    imem_req_ready = 1'b0;
    step(); // c2
    chk("bp_c2_req_v", {31'b0, s_req_v}, 32'h1);
    chk("bp_c2_addr",  s_req_a, 32'hFFFF_FFF8);
    imem_req_ready = 1'b1;
    step(); // c3
    chk("bp_c3_req_v", {31'b0, s_req_v}, 32'h1);
    chk("bp_c3_addr",  s_req_a, 32'hFFFF_FFF8);
    imem_req_ready = 1'b0;
    step(); // c4
    chk("bp_c4_req_v", {31'b0, s_req_v}, 32'h1);
    chk("bp_c4_addr",  s_req_a, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    step(); // c5
    chk("bp_c5_addr",  s_req_a, 32'hFFFF_FFFC);
    chk_instr("bp_c5", 32'hFFFF_FFF8);
    step(); // c6
    chk("bp_c6_addr",  s_req_a, 32'h0);
    chk("bp_c6_ifv",   {31'b0, s_ifv}, 32'h0);
    step(); // c7
    chk_instr("bp_c7", 32'hFFFF_FFFC);
    chk("bp_c7_addr",  s_req_a, 32'h4);
    step(); // c8
    chk_instr("bp_c8", 32'h0);

    // Reset mid-operation with a full buffer
    do_reset();
    lat = 1;
    step(); // c1
    step(); // c2
    stall = 1'b1;
    step(); // c3
    step(); // c4
    chk_instr("mr_c4", 32'h0);
    chk("mr_c4_req_v", {31'b0, s_req_v}, 32'h0);
    rst_n = 1'b0;
    mq.delete();
    step(); // c5: reset sampled at the end of this cycle
    rst_n = 1'b1;
    stall = 1'b0;
    step(); // c6
    chk("mr_c6_ifv",   {31'b0, s_ifv}, 32'h0);
    chk("mr_c6_instr", s_instr, 32'h13);
    chk("mr_c6_pc",    s_ifpc, 32'h0);
    chk("mr_c6_req_v", {31'b0, s_req_v}, 32'h1);
    chk("mr_c6_addr",  s_req_a, 32'h0);
    step(); // c7
    chk("mr_c7_addr",  s_req_a, 32'h4);
    step(); // c8
    chk_instr("mr_c8", 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
